lsu_mem_ctrl: RTL and testbench

- Multi-cycle load/store memory controller between the execute stage (address, store data, funct3) and a variable-latency data SRAM port.
- Replaces the single-cycle combinational memory path.
- Per access: one valid/ready request upstream, one request/response transaction downstream, then a one-cycle done pulse with the aligned, extended load data or a fault flag.

---
 rtl/lsu_mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store controller: one upstream valid/ready access becomes one memory request/response, then a done pulse.
// Optional LSU_TIMEOUT_EN: abandon a memory transaction after TIMEOUT_CYCLES cycles in REQ/WAIT and report a fault.
module lsu_mem_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [2:0]        in_funct3,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_rdata,
    output logic              done_fault
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic [3:0]        mem_wstrb_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        off_reg;
    logic [DATA_W-1:0] done_rdata_reg;
    logic              done_fault_reg;

    logic [1:0]        off;
    logic              illegal;
    logic              misaligned;
    logic              fault_next;
    logic [3:0]        wstrb_next;
    logic [DATA_W-1:0] wdata_next;
    logic [7:0]        rsp_byte;
    logic [15:0]       rsp_half;
    logic [DATA_W-1:0] load_data;
    logic              timeout_hit;

    assign off = in_addr[1:0];

    // Access decode; funct3[1:0] is the size code for both loads and stores.
    always_comb begin
        if (in_we) begin
            illegal = in_funct3[2] | (in_funct3[1:0] == 2'b11);
        end else begin
            illegal = (in_funct3 == 3'b011) | (in_funct3[2:1] == 2'b11);
        end
        case (in_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase
        fault_next = illegal | misaligned;
        wstrb_next = 4'b0000;
        wdata_next = '0;
        if (in_we) begin
            case (in_funct3[1:0])
                2'b00: begin
                    wstrb_next = 4'b0001 << off;
                    wdata_next = {4{in_wdata[7:0]}};
                end
                2'b01: begin
                    wstrb_next = 4'b0011 << off;
                    wdata_next = {2{in_wdata[15:0]}};
                end
                default: begin
                    wstrb_next = 4'b1111;
                    wdata_next = in_wdata;
                end
            endcase
        end
    end

    assign rsp_byte = mem_rsp_rdata[{off_reg, 3'b000} +: 8];
    assign rsp_half = mem_rsp_rdata[{off_reg[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{(DATA_W-8){rsp_byte[7]}}, rsp_byte};
            3'b001:  load_data = {{(DATA_W-16){rsp_half[15]}}, rsp_half};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, rsp_byte};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, rsp_half};
            default: load_data = mem_rsp_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg == IDLE) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == REQ || state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    // Fires in the last allowed cycle so DONE follows exactly TIMEOUT_CYCLES cycles of REQ/WAIT.
    assign timeout_hit = (state_reg == REQ || state_reg == WAIT) && (cnt_reg == TIMEOUT_LIMIT - 8'd1);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wstrb_reg  <= 4'b0000;
            funct3_reg     <= 3'b000;
            off_reg        <= 2'b00;
            done_rdata_reg <= '0;
            done_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        funct3_reg <= in_funct3;
                        off_reg    <= off;
                        if (fault_next) begin
                            done_fault_reg <= 1'b1;
                            done_rdata_reg <= '0;
                            state_reg      <= DONE;
                        end else begin
                            mem_we_reg    <= in_we;
                            mem_addr_reg  <= {in_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_reg <= wdata_next;
                            mem_wstrb_reg <= wstrb_next;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (timeout_hit) begin
                        done_fault_reg <= 1'b1;
                        done_rdata_reg <= '0;
                        state_reg      <= DONE;
                    end else if (mem_req_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        done_fault_reg <= 1'b0;
                        done_rdata_reg <= mem_we_reg ? '0 : load_data;
                        state_reg      <= DONE;
                    end else if (timeout_hit) begin
                        done_fault_reg <= 1'b1;
                        done_rdata_reg <= '0;
                        state_reg      <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign mem_req_valid = (state_reg == REQ);
    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign mem_wstrb     = mem_wstrb_reg;
    assign done_valid    = (state_reg == DONE);
    assign done_rdata    = done_rdata_reg;
    assign done_fault    = done_fault_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against an arithmetic reference model of the RV32I access rules.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [31:0] in_addr;
    logic [2:0]  in_funct3;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        done_fault;

    int checks   = 0;
    int failures = 0;
    int txn_id   = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_we(in_we),
        .in_addr(in_addr),
        .in_funct3(in_funct3),
        .in_wdata(in_wdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata),
        .done_valid(done_valid),
        .done_rdata(done_rdata),
        .done_fault(done_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn_id, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: size in bytes from funct3, lanes by multiplication/shift, extension by masking.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic fault, output logic [3:0] strb,
                                  output logic [31:0] sdata, output logic [31:0] ldata);
        int size;
        int off;
        logic legal;
        logic [31:0] mask;
        logic [31:0] tmp;
        size  = 1 << int'(f3[1:0]);
        off   = int'(addr[1:0]);
        legal = we ? (f3 < 3'd3) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        fault = !legal || ((off % size) != 0);
        strb  = we ? 4'(((1 << size) - 1) << off) : 4'b0000;
        if (size == 1)      sdata = {24'd0, wdata[7:0]} * 32'h0101_0101;
        else if (size == 2) sdata = {16'd0, wdata[15:0]} * 32'h0001_0001;
        else                sdata = wdata;
        mask  = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        tmp   = rdata >> (8 * off);
        ldata = tmp & mask;
        if (!f3[2] && size < 4 && ldata[8 * size - 1]) ldata = ldata | ~mask;
    endfunction

    task automatic check_req(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] sdata);
        check("req_valid", 32'(mem_req_valid), 32'd1);
        check("req_addr", mem_addr, {addr[31:2], 2'b00});
        check("req_we", 32'(mem_we), 32'(we));
        check("req_wstrb", 32'(mem_wstrb), 32'(strb));
        if (we) check("req_wdata", mem_wdata, sdata);
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdy_dly, input int rsp_dly, input bit noise);
        logic efault;
        logic [3:0] estrb;
        logic [31:0] esdata;
        logic [31:0] eldata;
        txn_id++;
        model(we, f3, addr, wdata, rdata, efault, estrb, esdata, eldata);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_we     = we;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wdata;
        step();
        in_valid  = 1'b0;
        in_addr   = $urandom;
        in_wdata  = $urandom;
        if (efault) begin
            check("fault_done_valid", 32'(done_valid), 32'd1);
            check("fault_flag", 32'(done_fault), 32'd1);
            check("fault_rdata", done_rdata, 32'd0);
            check("fault_no_req", 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                check_req(we, addr, estrb, esdata);
                if (noise) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = $urandom;
                end
                step();
                mem_rsp_valid = 1'b0;
            end
            check_req(we, addr, estrb, esdata);
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                check("wait_req_low", 32'(mem_req_valid), 32'd0);
                check("wait_no_done", 32'(done_valid), 32'd0);
                step();
            end
            check("wait_req_low", 32'(mem_req_valid), 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            step();
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            check("done_valid", 32'(done_valid), 32'd1);
            check("done_fault", 32'(done_fault), 32'd0);
            check("done_rdata", done_rdata, we ? 32'd0 : eldata);
        end
        step();
        check("done_pulse_end", 32'(done_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        $display("txn %0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h fault=%0d exp_load=%h rdy_dly=%0d rsp_dly=%0d",
                 txn_id, we, f3, addr, wdata, rdata, efault, eldata, rdy_dly, rsp_dly);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_we         = 1'b0;
        in_addr       = 32'd0;
        in_funct3     = 3'd0;
        in_wdata      = 32'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_rdata", done_rdata, 32'd0);
        check("rst_done_fault", 32'(done_fault), 32'd0);

        // Directed accesses from the test plan.
        run_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0);
        run_txn(1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_7F01, 0, 0, 1'b0);
        run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_7F01, 0, 1, 1'b0);
        run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h5555_5555, 0, 5, 1'b0);
        run_txn(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(1'b0, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 3, 0, 1'b1);

        // Reset while waiting for the response, then a stale response must be ignored.
        txn_id++;
        in_valid  = 1'b1;
        in_we     = 1'b0;
        in_funct3 = 3'b010;
        in_addr   = 32'h8000_0020;
        step();
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'h1111_2222;
            step();
            check("stale_no_done", 32'(done_valid), 32'd0);
            check("stale_in_ready", 32'(in_ready), 32'd1);
        end
        mem_rsp_valid = 1'b0;
        $display("txn %0d reset during WAIT, stale response ignored", txn_id);

`ifdef LSU_TIMEOUT_EN
        txn_id++;
        in_valid  = 1'b1;
        in_we     = 1'b0;
        in_funct3 = 3'b010;
        in_addr   = 32'h8000_0040;
        step();
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("to_no_done", 32'(done_valid), 32'd0);
            step();
            mem_req_ready = 1'b0;
        end
        check("to_done_valid", 32'(done_valid), 32'd1);
        check("to_fault", 32'(done_fault), 32'd1);
        check("to_rdata", done_rdata, 32'd0);
        check("to_req_low", 32'(mem_req_valid), 32'd0);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAD0_BAD0;
        step();
        mem_rsp_valid = 1'b0;
        check("to_late_ignored", 32'(done_valid), 32'd0);
        $display("txn %0d timeout after 10 cycles, late response ignored", txn_id);
        run_txn(1'b0, 3'b010, 32'h8000_0044, 32'h0, 32'h0BAD_F00D, 1, 2, 1'b0);
`endif

        // Randomized traffic; delays stay short enough never to reach a 10-cycle timeout.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            f = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'b01) a[0] = 1'b0;
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), f, a, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
